// File: rtl/event_sync_rx.sv
// event_sync_rx: receive side of a 4-phase level handshake from a foreign clock domain.
// Synchronises the request, acknowledges it, counts events in a saturating pending
// counter and hands them out one per accepted valid/ready beat.
module event_sync_rx #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_W       = 4
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             req_async_i,
    output logic             ack_o,
    output logic             evt_valid_o,
    input  logic             evt_ready_i,
    output logic [CNT_W-1:0] pending_o,
    output logic             overflow_o,
    input  logic             clear_i
);

    localparam logic [0:0]       ST_IDLE   = 1'b0;
    localparam logic [0:0]       ST_ACK_HI = 1'b1;
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   req_s;
    logic [0:0]             state_q;
    logic [0:0]             state_d;
    logic                   capture;
    logic                   pop;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_d;
    logic                   ovf_q;
    logic                   ovf_d;
    logic                   valid_q;

    assign req_s = sync_q[SYNC_STAGES-1];
    assign pop   = valid_q & evt_ready_i;

    // Request synchroniser: the only logic that samples req_async_i.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], req_async_i};
        end
    end

    // Handshake state register; ack is taken straight from it so it cannot glitch.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; capture fires once on the IDLE -> ACK_HI transition.
    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_s) begin
                    state_d = ST_ACK_HI;
                    capture = 1'b1;
                end
            end
            ST_ACK_HI: begin
                if (!req_s) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Pending counter update: clear wins, capture+pop cancel, saturate on overflow.
    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (clear_i) begin
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if (capture && pop) begin
            cnt_d = cnt_q;
        end else if (capture) begin
            if (cnt_q == CNT_MAX) begin
                ovf_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (pop) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Counter, sticky overflow and a registered copy of (count != 0).
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            valid_q <= (cnt_d != '0);
        end
    end

    assign ack_o       = (state_q == ST_ACK_HI);
    assign evt_valid_o = valid_q;
    assign pending_o   = cnt_q;
    assign overflow_o  = ovf_q;

endmodule

// File: tb/tb_event_sync_rx.sv
// Testbench for event_sync_rx: vector table, directed corner sequences and a
// randomized run against an event-level reference model. Two instances share
// stimulus: a default-width one and a 2-bit counter one for saturation.
module tb_event_sync_rx;

    localparam int STAGES = 2;
    localparam int MAX_A  = 15;
    localparam int MAX_B  = 3;

    logic       clk;
    logic       rstn;
    logic       req;
    logic       rdy;
    logic       clr;
    logic       ack_a, ack_b;
    logic       valid_a, valid_b;
    logic [3:0] pend_a;
    logic [1:0] pend_b;
    logic       ovf_a, ovf_b;

    int n_tests = 0;
    int n_fail  = 0;

    event_sync_rx #(.SYNC_STAGES(STAGES), .CNT_W(4)) dut_a (
        .clk_i(clk), .rstn_i(rstn), .req_async_i(req), .ack_o(ack_a),
        .evt_valid_o(valid_a), .evt_ready_i(rdy), .pending_o(pend_a),
        .overflow_o(ovf_a), .clear_i(clr)
    );

    event_sync_rx #(.SYNC_STAGES(STAGES), .CNT_W(2)) dut_b (
        .clk_i(clk), .rstn_i(rstn), .req_async_i(req), .ack_o(ack_b),
        .evt_valid_o(valid_b), .evt_ready_i(rdy), .pending_o(pend_b),
        .overflow_o(ovf_b), .clear_i(clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: the request seen by the handshake is the input sampled
    // STAGES edges earlier; one event per rising level of that delayed request.
    bit hist[$];
    bit m_ack;
    int m_cnt_a, m_cnt_b;
    bit m_ovf_a, m_ovf_b;
    bit m_rs, m_cap;

    function automatic void upd_cnt(inout int cnt, inout bit ovf, input int maxv,
                                    input bit cap, input bit ready, input bit clear);
        bit p;
        p = (cnt != 0) && ready;
        if (clear) begin
            cnt = 0;
            ovf = 1'b0;
        end else if (cap && !p) begin
            if (cnt < maxv) cnt = cnt + 1;
            else ovf = 1'b1;
        end else if (p && !cap) begin
            cnt = cnt - 1;
        end
    endfunction

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            hist.delete();
            m_ack   = 1'b0;
            m_cnt_a = 0;
            m_cnt_b = 0;
            m_ovf_a = 1'b0;
            m_ovf_b = 1'b0;
        end else begin
            m_rs  = (hist.size() >= STAGES) ? hist[hist.size() - STAGES] : 1'b0;
            m_cap = m_rs && !m_ack;
            m_ack = m_rs;
            upd_cnt(m_cnt_a, m_ovf_a, MAX_A, m_cap, rdy, clr);
            upd_cnt(m_cnt_b, m_ovf_b, MAX_B, m_cap, rdy, clr);
            hist.push_back(req);
            if (hist.size() > STAGES) void'(hist.pop_front());
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        bit req;
        bit rdy;
        bit clr;
        bit ack;
        bit valid;
        int pend;
        bit ovf;
    } vec_t;

    vec_t vt[$];

    function automatic void add(bit r, bit y, bit c, bit a, bit v, int p, bit o);
        vec_t e;
        e.req = r; e.rdy = y; e.clr = c; e.ack = a; e.valid = v; e.pend = p; e.ovf = o;
        vt.push_back(e);
    endfunction

    task automatic handshake();
        req = 1'b1;
        repeat (4) @(negedge clk);
        req = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    int n;
    int hold;

    initial begin
        rstn = 1'b0; req = 1'b0; rdy = 1'b0; clr = 1'b0;

        // One 10-cycle request: single event, ack 3 edges after rise and fall.
        for (int i = 0; i < 10; i++) add(1, 0, 0, (i >= 2), (i >= 2), (i >= 2) ? 1 : 0, 0);
        add(0, 0, 0, 1, 1, 1, 0);
        add(0, 0, 0, 1, 1, 1, 0);
        add(0, 0, 0, 0, 1, 1, 0);
        add(0, 0, 0, 0, 1, 1, 0);
        add(0, 1, 0, 0, 0, 0, 0);
        // Capture edge coincident with clear: event dropped, handshake completes.
        add(1, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 0);
        add(1, 0, 1, 1, 0, 0, 0);
        add(0, 0, 0, 1, 0, 0, 0);
        add(0, 0, 0, 1, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0);

        repeat (2) @(negedge clk);
        chk("rst_ack", ack_a, 0);
        chk("rst_valid", valid_a, 0);
        chk("rst_pend", pend_a, 0);
        chk("rst_ovf", ovf_a, 0);
        rstn = 1'b1;

        foreach (vt[i]) begin
            req = vt[i].req; rdy = vt[i].rdy; clr = vt[i].clr;
            @(negedge clk);
            chk($sformatf("vec%0d_ack", i), ack_a, vt[i].ack);
            chk($sformatf("vec%0d_valid", i), valid_a, vt[i].valid);
            chk($sformatf("vec%0d_pend", i), pend_a, vt[i].pend);
            chk($sformatf("vec%0d_ovf", i), ovf_a, vt[i].ovf);
            chk($sformatf("vec%0d_pend_b", i), pend_b, vt[i].pend);
        end
        rdy = 1'b0; clr = 1'b0; req = 1'b0;

        // Three events, then drain with ready held high.
        repeat (3) handshake();
        chk("three_pend", pend_a, 3);
        rdy = 1'b1;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            if (!valid_a) break;
            n++;
            @(negedge clk);
        end
        rdy = 1'b0;
        chk("drain_valid_cycles", n, 3);
        chk("drain_pend", pend_a, 0);
        chk("drain_valid", valid_a, 0);

        // Saturation in the 2-bit instance.
        repeat (4) handshake();
        chk("sat_pend_a", pend_a, 4);
        chk("sat_ovf_a", ovf_a, 0);
        chk("sat_pend_b", pend_b, 3);
        chk("sat_ovf_b", ovf_b, 1);
        rdy = 1'b1;
        @(negedge clk);
        rdy = 1'b0;
        chk("sat_pop_pend_b", pend_b, 2);
        chk("sat_pop_ovf_b", ovf_b, 1);
        chk("sat_pop_pend_a", pend_a, 3);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("clr_pend_a", pend_a, 0);
        chk("clr_pend_b", pend_b, 0);
        chk("clr_ovf_b", ovf_b, 0);
        chk("clr_valid_b", valid_b, 0);

        // Capture coincident with pop at count 2.
        repeat (2) handshake();
        chk("cp_pre_pend", pend_a, 2);
        req = 1'b1;
        repeat (2) @(negedge clk);
        rdy = 1'b1;
        @(negedge clk);
        rdy = 1'b0;
        chk("cp_pend_a", pend_a, 2);
        chk("cp_pend_b", pend_b, 2);
        chk("cp_ack", ack_a, 1);
        req = 1'b0;
        repeat (4) @(negedge clk);
        chk("cp_ack_low", ack_a, 0);

        // Asynchronous reset while in ACK_HI with 5 pending.
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        repeat (4) handshake();
        req = 1'b1;
        repeat (3) @(negedge clk);
        chk("pre_rst_pend", pend_a, 5);
        chk("pre_rst_ack", ack_a, 1);
        chk("pre_rst_ovf_b", ovf_b, 1);
        #2 rstn = 1'b0;
        #1;
        chk("arst_ack", ack_a, 0);
        chk("arst_pend", pend_a, 0);
        chk("arst_valid", valid_a, 0);
        chk("arst_ovf_b", ovf_b, 0);
        chk("arst_pend_b", pend_b, 0);
        @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        chk("rel_early_ack", ack_a, 0);
        chk("rel_early_pend", pend_a, 0);
        @(negedge clk);
        chk("rel_ack", ack_a, 1);
        chk("rel_pend", pend_a, 1);
        chk("rel_pend_b", pend_b, 1);
        req = 1'b0;
        repeat (4) @(negedge clk);

        // Randomized traffic against the reference model.
        hold = 0;
        for (int i = 0; i < 1500; i++) begin
            chk("rnd_ack_a", ack_a, m_ack);
            chk("rnd_ack_b", ack_b, m_ack);
            chk("rnd_pend_a", pend_a, m_cnt_a);
            chk("rnd_valid_a", valid_a, (m_cnt_a != 0));
            chk("rnd_ovf_a", ovf_a, m_ovf_a);
            chk("rnd_pend_b", pend_b, m_cnt_b);
            chk("rnd_valid_b", valid_b, (m_cnt_b != 0));
            chk("rnd_ovf_b", ovf_b, m_ovf_b);
            if (hold == 0) begin
                req  = ~req;
                hold = $urandom_range(1, 12);
            end else begin
                hold--;
            end
            rdy = ($urandom_range(0, 3) == 0);
            clr = ($urandom_range(0, 63) == 0);
            @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
